// File: rtl/rbr_to_bin_conv_if.sv
// Valid/ready bus for the RBR-to-binary converter: RBR words in, two's-complement results out.
// The master modport is the environment side; the slave modport is the converter.
interface rbr_to_bin_conv_if #(
    parameter int W = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     out_data;
    logic           out_zero;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_zero,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_zero,
        input  out_ready
    );
endinterface

// File: rtl/rbr_to_bin_conv.sv
// Converts one RBR word to two's complement as P - N, subtracting CW bits per cycle.
// Latency: out_valid rises W/CW edges after the accept edge; one word in flight.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module rbr_to_bin_conv #(
    parameter int W  = 64,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clr,
    rbr_to_bin_conv_if.slave  bus
);
    localparam int NCH   = W / CW;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] n;
    } digits_t;

    state_t           state_q;
    digits_t          ops_q;
    digits_t          split;
    logic [W-1:0]     res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             out_valid_q;
    logic [W:0]       out_data_q;
    logic             out_zero_q;

    logic [CW:0]      chunk_sum;
    logic [W-1:0]     res_next;
    logic [W:0]       final_val;
    int               base;

    // 11 -> +1, 00 -> -1, 01/10 -> 0 (neither vector set)
    always_comb begin
        split = '0;
        for (int i = 0; i < W; i++) begin
            split.p[i] =  bus.in_data[2*i+1] &  bus.in_data[2*i];
            split.n[i] = ~bus.in_data[2*i+1] & ~bus.in_data[2*i];
        end
    end

    // P + ~N + 1 over W bits; the top result bit is the sign of the
    // extended sum, where P extends with 0 and ~N extends with 1.
    always_comb begin
        base      = int'(cnt_q) * CW;
        chunk_sum = {1'b0, ops_q.p[base +: CW]}
                  + {1'b0, ~ops_q.n[base +: CW]}
                  + {{CW{1'b0}}, carry_q};
        res_next  = res_q;
        res_next[base +: CW] = chunk_sum[CW-1:0];
        final_val = {~chunk_sum[CW], res_next};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            ops_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        ops_q   <= split;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    carry_q <= chunk_sum[CW];
                    res_q   <= res_next;
                    if (cnt_q == LAST) begin
                        out_data_q  <= final_val;
                        out_zero_q  <= (final_val == '0);
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_rbr_to_bin_conv.sv
// Directed bench for rbr_to_bin_conv at W=8, CW=4 (two chunk cycles per word).
module tb_rbr_to_bin_conv;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk;
    logic arst_n;
    logic clr;
    int   checks;
    int   errors;

    rbr_to_bin_conv_if #(.W(W)) bus ();

    rbr_to_bin_conv #(.W(W), .CW(CW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a word for exactly one edge (DUT must be IDLE); returns at the following negedge.
    task automatic send_word(input logic [2*W-1:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_out_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++;
        if (bus.out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data: got %h expected 000", bus.out_data); end
        checks++;
        if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b expected 0", bus.out_zero); end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_all_plus;
        int cyc;
        send_word(16'hFFFF);
        wait_out_valid(cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL plus_latency: got %0d expected 2", cyc); end
        checks++;
        if (bus.out_data !== 9'h0FF) begin errors++; $display("FAIL plus_data: got %h expected 0ff", bus.out_data); end
        checks++;
        if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL plus_zero: got %b expected 0", bus.out_zero); end
        pop();
    endtask

    task automatic test_all_minus;
        int cyc;
        send_word(16'h0000);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h101) begin errors++; $display("FAIL minus_data: got %h expected 101", bus.out_data); end
        checks++;
        if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL minus_zero: got %b expected 0", bus.out_zero); end
        pop();
    endtask

    task automatic test_chunk_borrow;
        int cyc;
        send_word(16'h5754);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h00F) begin errors++; $display("FAIL borrow_5754: got %h expected 00f", bus.out_data); end
        pop();
        send_word(16'hC555);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h040) begin errors++; $display("FAIL borrow_c555: got %h expected 040", bus.out_data); end
        pop();
    endtask

    task automatic test_zero_digits;
        int cyc;
        send_word(16'hAAAA);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h000) begin errors++; $display("FAIL zero_aaaa_data: got %h expected 000", bus.out_data); end
        checks++;
        if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL zero_aaaa_flag: got %b expected 1", bus.out_zero); end
        pop();
        send_word(16'h5555);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h000) begin errors++; $display("FAIL zero_5555_data: got %h expected 000", bus.out_data); end
        checks++;
        if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL zero_5555_flag: got %b expected 1", bus.out_zero); end
        pop();
    endtask

    task automatic test_backpressure;
        int cyc;
        send_word(16'h0000);
        wait_out_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++;
            if (bus.out_data !== 9'h101) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 101", i, bus.out_data); end
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        pop();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra_word: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_async_reset;
        int cyc;
        send_word(16'hFFFF);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_discard: got %b expected 0", bus.out_valid); end
        send_word(16'hFFFF);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h0FF) begin errors++; $display("FAIL arst_after_data: got %h expected 0ff", bus.out_data); end
        pop();
    endtask

    task automatic test_clr;
        int cyc;
        // clr beats a simultaneous accept in IDLE
        @(negedge clk);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_idle_ready: got %b expected 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_idle_no_accept: got %b expected 0", bus.out_valid); end
        // clr in DONE together with out_ready and in_valid
        send_word(16'h0000);
        wait_out_valid(cyc);
        clr           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        clr           = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_done_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_done_ready: got %b expected 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_done_no_accept: got %b expected 0", bus.out_valid); end
        send_word(16'hFFFF);
        wait_out_valid(cyc);
        checks++;
        if (bus.out_data !== 9'h0FF) begin errors++; $display("FAIL clr_after_data: got %h expected 0ff", bus.out_data); end
        pop();
    endtask

    task automatic test_back_to_back;
        logic [11:0] mask;
        mask = '0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hFFFF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            mask[k] = bus.out_valid;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_data !== 9'h0FF) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected 0ff", k, bus.out_data); end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (mask !== 12'h444) begin errors++; $display("FAIL b2b_valid_pattern: got %h expected 444", mask); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        arst_n        = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_all_plus();
        test_all_minus();
        test_chunk_borrow();
        test_zero_digits();
        test_backpressure();
        test_async_reset();
        test_clr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
